// File: rtl/backup_ram_ctrl.sv
// Backup-RAM strobe/DTACK controller for two 32Kx8 byte-lane SRAMs on the 68000 bus.
// Optional write-protect latch enabled with `define BACKUP_RAM_LOCK_EN.
module backup_ram_ctrl #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic [23:1] M68K_ADDR,
    input  logic        nAS,
    input  logic        nLDS,
    input  logic        nUDS,
    input  logic        M68K_RW,
    output logic [14:0] SRAM_ADDR,
    output logic        nCE,
    output logic        nOEL,
    output logic        nOEU,
    output logic        nWEL,
    output logic        nWEU,
    output logic        nDTACK_SRAM,
    output logic        LOCKED
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       ram_hit;

    assign ram_hit = (M68K_ADDR[23:20] == 4'hD);

`ifdef BACKUP_RAM_LOCK_EN
    logic reg_done;
    logic reg_hit;

    assign reg_hit = !nAS && !M68K_RW && !nLDS && (M68K_ADDR[23:16] == 8'h3A) &&
                     ((M68K_ADDR[4:1] == 4'b0110) || (M68K_ADDR[4:1] == 4'b1110));

    // reg_done makes each lock/unlock act once per address strobe
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            LOCKED   <= 1'b1;
            reg_done <= 1'b0;
        end else if (nAS) begin
            reg_done <= 1'b0;
        end else if (reg_hit && !reg_done) begin
            LOCKED   <= (M68K_ADDR[4:1] == 4'b0110);
            reg_done <= 1'b1;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = &{1'b0, M68K_ADDR[19:16]};
    assign LOCKED      = 1'b0;
`endif

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            SRAM_ADDR   <= 15'd0;
            nCE         <= 1'b1;
            nOEL        <= 1'b1;
            nOEU        <= 1'b1;
            nWEL        <= 1'b1;
            nWEU        <= 1'b1;
            nDTACK_SRAM <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!nAS && ram_hit) begin
                        state     <= ACCESS;
                        cnt       <= CNT_INIT;
                        SRAM_ADDR <= M68K_ADDR[15:1];
                        nCE       <= 1'b0;
                        nOEL      <= M68K_RW ? nLDS : 1'b1;
                        nOEU      <= M68K_RW ? nUDS : 1'b1;
                        nWEL      <= (!M68K_RW && !LOCKED) ? nLDS : 1'b1;
                        nWEU      <= (!M68K_RW && !LOCKED) ? nUDS : 1'b1;
                    end
                end
                ACCESS: begin
                    if (nAS) begin
                        state       <= IDLE;
                        nCE         <= 1'b1;
                        nOEL        <= 1'b1;
                        nOEU        <= 1'b1;
                        nWEL        <= 1'b1;
                        nWEU        <= 1'b1;
                        nDTACK_SRAM <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        // nWE rises with DTACK so data/CE are held one cycle past the write
                        state       <= ACK;
                        nDTACK_SRAM <= 1'b0;
                        nWEL        <= 1'b1;
                        nWEU        <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    if (nAS) begin
                        state       <= IDLE;
                        nCE         <= 1'b1;
                        nOEL        <= 1'b1;
                        nOEU        <= 1'b1;
                        nWEL        <= 1'b1;
                        nWEU        <= 1'b1;
                        nDTACK_SRAM <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_backup_ram_ctrl.sv
// Randomized bench for backup_ram_ctrl: each bus cycle's expected strobe timeline is
// computed arithmetically from the cycle's attributes and the edge index.
`timescale 1ns/1ps
module tb_backup_ram_ctrl;

    localparam int W = 3;
`ifdef BACKUP_RAM_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:1] addr = '0;
    logic        n_as = 1'b1, n_lds = 1'b1, n_uds = 1'b1, rw = 1'b1;
    logic [14:0] sram_addr;
    logic        n_ce, n_oel, n_oeu, n_wel, n_weu, n_dtack, locked;

    int vectors = 0;
    int errors  = 0;

    // reference state
    bit          m_locked;
    logic [14:0] m_addr;

    backup_ram_ctrl #(.WAIT_CYCLES(W)) dut (
        .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr), .nAS(n_as), .nLDS(n_lds),
        .nUDS(n_uds), .M68K_RW(rw), .SRAM_ADDR(sram_addr), .nCE(n_ce), .nOEL(n_oel),
        .nOEU(n_oeu), .nWEL(n_wel), .nWEU(n_weu), .nDTACK_SRAM(n_dtack), .LOCKED(locked)
    );

    initial forever #21 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // packed order {nCE,nOEL,nOEU,nWEL,nWEU,nDTACK,LOCKED}
    function automatic logic [6:0] outs();
        return {n_ce, n_oel, n_oeu, n_wel, n_weu, n_dtack, locked};
    endfunction

    task automatic check_idle(input string tag);
        check(tag, 32'(outs()), 32'({6'b111111, m_locked}));
        check({tag, "_addr"}, 32'(sram_addr), 32'(m_addr));
    endtask

    // One nAS assertion lasting len sampled edges, starting at posedge+2ns; returns at posedge+2ns.
    task automatic bus_cycle(input logic [23:0] ba, input bit wr, input bit lds,
                             input bit uds, input int len, input int gap);
        bit hit, lk;
        logic [6:0] exp;
        hit  = (ba[23:20] == 4'hD);
        lk   = m_locked;
        addr = ba[23:1]; rw = !wr; n_lds = lds; n_uds = uds; n_as = 1'b0;
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #2;
            if (k == 1) begin
                if (hit) m_addr = ba[15:1];
                if (LOCK_EN && wr && !lds && ba[23:16] == 8'h3A) begin
                    if (ba[4:1] == 4'b0110) m_locked = 1'b1;
                    if (ba[4:1] == 4'b1110) m_locked = 1'b0;
                end
            end
            exp = {6'b111111, m_locked};
            if (hit && k <= len) begin
                exp[6] = 1'b0;
                exp[5] = wr ? 1'b1 : lds;
                exp[4] = wr ? 1'b1 : uds;
                exp[3] = (wr && !lk && k <= W) ? lds : 1'b1;
                exp[2] = (wr && !lk && k <= W) ? uds : 1'b1;
                exp[1] = (k >= W + 1) ? 1'b0 : 1'b1;
            end
            check(hit ? "ram_strobes" : "nonram_strobes", 32'(outs()), 32'(exp));
            check("sram_addr", 32'(sram_addr), 32'(m_addr));
            // lane strobes changing after entry must be ignored
            if (k == 1 && hit && len > 1) begin
                n_lds = 1'($urandom); n_uds = 1'($urandom);
            end
            if (k == len) begin
                n_as = 1'b1; n_lds = 1'b1; n_uds = 1'b1;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #2;
            check_idle("gap_idle");
        end
    endtask

    initial begin
        logic [23:0] ba;
        bit wr, lds, uds;
        int kind;

        m_locked = LOCK_EN;
        m_addr   = '0;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset_state");
        rst = 1'b0;
        @(posedge clk); #2;
        check_idle("post_reset");

        // word read at D00010
        bus_cycle(24'hD00010, 1'b0, 1'b0, 1'b0, W + 2, 1);
        check("read_addr_0008", 32'(m_addr), 32'h0008);
        // upper-byte write at D0FFFE (protected when lock feature present)
        bus_cycle(24'hD0FFFE, 1'b1, 1'b1, 1'b0, W + 2, 1);
        // unlock, then lower-byte write
        bus_cycle(24'h3A001D, 1'b1, 1'b0, 1'b1, 2, 1);
        check("unlocked", 32'(locked), 32'h0);
        bus_cycle(24'hD00001, 1'b1, 1'b0, 1'b1, W + 3, 1);
        // aborted cycle: nAS released after first edge
        bus_cycle(24'hD00040, 1'b1, 1'b0, 1'b0, 1, 1);
        bus_cycle(24'hD00042, 1'b0, 1'b0, 1'b0, 2, 0);
        // non-RAM reads
        bus_cycle(24'hE00000, 1'b0, 1'b0, 1'b0, W + 2, 1);
        bus_cycle(24'h100000, 1'b0, 1'b0, 1'b0, W + 2, 1);
        // relock
        bus_cycle(24'h3A000D, 1'b1, 1'b0, 1'b1, 2, 1);

        // asynchronous reset in the middle of a write
        bus_cycle(24'h3A001D, 1'b1, 1'b0, 1'b1, 2, 0);
        addr = 23'(24'hD00001 >> 1); rw = 1'b0; n_lds = 1'b0; n_uds = 1'b1; n_as = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        m_locked = LOCK_EN;
        m_addr   = '0;
        check("async_reset_outs", 32'(outs()), 32'({6'b111111, LOCK_EN}));
        check("async_reset_addr", 32'(sram_addr), 32'h0);
        n_as = 1'b1; n_lds = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check_idle("after_reset");
        bus_cycle(24'hD00001, 1'b1, 1'b0, 1'b1, W + 2, 1);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom);
            lds  = 1'($urandom);
            uds  = 1'($urandom);
            case (kind)
                0, 1, 2, 3, 4: ba = {4'hD, 20'($urandom)};
                5:  ba = 24'hE00000 | 24'($urandom_range(0, 16'hFFFF));
                6:  ba = {4'h1, 20'($urandom)};
                7:  begin ba = 24'h3A000D; wr = 1'b1; lds = 1'($urandom_range(0, 3) == 0); end
                8:  begin ba = 24'h3A001D; wr = 1'b1; lds = 1'($urandom_range(0, 3) == 0); end
                default: begin ba = {8'h3A, 16'($urandom)}; end
            endcase
            bus_cycle(ba, wr, lds, uds, $urandom_range(1, 7), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
